// File: rtl/wave_rom_scheduler.sv
// Shares one synchronous-read waveform ROM among NUM_VOICES voices: snapshots addresses on
// sample_strobe, issues one read per enabled voice, tags reads through the ROM latency, publishes all samples at once.
module wave_rom_scheduler #(
  parameter int NUM_VOICES = 3,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int ROM_LAT    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_strobe,
  input  logic [NUM_VOICES-1:0]        voice_en,
  input  logic [NUM_VOICES*ADDR_W-1:0] voice_addrs,
  output logic                         rom_en,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic [DATA_W-1:0]            rom_data,
  output logic [NUM_VOICES*DATA_W-1:0] voice_data,
  output logic                         data_valid,
  output logic                         busy,
  output logic [7:0]                   overrun_cnt,
  output logic [1:0]                   state_dbg
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                       state;
  logic [NUM_VOICES-1:0]        pend;
  logic [NUM_VOICES*ADDR_W-1:0] snap_addrs;
  logic [IDX_W-1:0]             cur_idx;
  logic [ROM_LAT-1:0]           tag_v;
  logic [IDX_W-1:0]             tag_idx [ROM_LAT];
  logic [NUM_VOICES*DATA_W-1:0] slots;
  logic [NUM_VOICES*DATA_W-1:0] slots_next;

  logic                  accept;
  logic [NUM_VOICES-1:0] src_mask;
  logic [IDX_W-1:0]      sel_idx;
  logic [NUM_VOICES-1:0] sel_bit;
  logic [ADDR_W-1:0]     sel_addr;
  logic                  in_flight;
  logic                  exit_v;
  logic [IDX_W-1:0]      exit_idx;

  assign state_dbg = state;
  assign accept    = sample_strobe && (state == IDLE || state == DONE);
  assign exit_v    = tag_v[ROM_LAT-1];
  assign exit_idx  = tag_idx[ROM_LAT-1];

  // Lowest-index pending voice; while accepting a strobe the live inputs stand in for the snapshot.
  always_comb begin
    src_mask = accept ? voice_en : pend;
    sel_idx  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (src_mask[i]) sel_idx = IDX_W'(i);
    end
    sel_bit  = NUM_VOICES'(1) << sel_idx;
    sel_addr = accept ? voice_addrs[int'(sel_idx)*ADDR_W +: ADDR_W]
                      : snap_addrs[int'(sel_idx)*ADDR_W +: ADDR_W];
  end

  // A tag in its last stage is leaving this edge, so only earlier stages count as in flight.
  always_comb begin
    in_flight = 1'b0;
    for (int i = 0; i < ROM_LAT - 1; i++) begin
      in_flight = in_flight | tag_v[i];
    end
  end

  // The landing sample is merged here so voice_data can capture it on the same edge.
  always_comb begin
    slots_next = slots;
    if (accept) begin
      slots_next = '0;
    end else if (exit_v) begin
      slots_next[int'(exit_idx)*DATA_W +: DATA_W] = rom_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend        <= '0;
      snap_addrs  <= '0;
      cur_idx     <= '0;
      tag_v       <= '0;
      slots       <= '0;
      rom_en      <= 1'b0;
      rom_addr    <= '0;
      voice_data  <= '0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      overrun_cnt <= '0;
      for (int i = 0; i < ROM_LAT; i++) tag_idx[i] <= '0;
    end else begin
      rom_en     <= 1'b0;
      rom_addr   <= '0;
      data_valid <= 1'b0;
      slots      <= slots_next;

      tag_v[0]   <= rom_en;
      tag_idx[0] <= cur_idx;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end

      if (sample_strobe && (state == ISSUE || state == DRAIN) && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;

      case (state)
        IDLE, DONE: begin
          if (accept) begin
            snap_addrs <= voice_addrs;
            if (|voice_en) begin
              state    <= ISSUE;
              busy     <= 1'b1;
              rom_en   <= 1'b1;
              rom_addr <= sel_addr;
              cur_idx  <= sel_idx;
              pend     <= voice_en & ~sel_bit;
            end else begin
              state      <= DONE;
              pend       <= '0;
              data_valid <= 1'b1;
              voice_data <= slots_next;
            end
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (|pend) begin
            rom_en   <= 1'b1;
            rom_addr <= sel_addr;
            cur_idx  <= sel_idx;
            pend     <= pend & ~sel_bit;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!in_flight) begin
            state      <= DONE;
            busy       <= 1'b0;
            data_valid <= 1'b1;
            voice_data <= slots_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_rom_scheduler.sv
// Directed bench: one scheduler with ROM_LAT=1 and one with ROM_LAT=2 share stimulus,
// each with its own ROM model returning addr[7:0]^0xA5.
module tb_wave_rom_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_strobe = 1'b0;
  logic [2:0]  voice_en = '0;
  logic [35:0] voice_addrs = '0;

  logic        rom_en1, rom_en2, data_valid1, data_valid2, busy1, busy2;
  logic [11:0] rom_addr1, rom_addr2;
  logic [7:0]  rom_data1, rom_data2, rom_pipe2, ovr1, ovr2;
  logic [23:0] vd1, vd2;
  logic [1:0]  st1, st2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wave_rom_scheduler #(.NUM_VOICES(3), .ADDR_W(12), .DATA_W(8), .ROM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sample_strobe(sample_strobe), .voice_en(voice_en),
    .voice_addrs(voice_addrs), .rom_en(rom_en1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .voice_data(vd1), .data_valid(data_valid1), .busy(busy1), .overrun_cnt(ovr1),
    .state_dbg(st1)
  );

  wave_rom_scheduler #(.NUM_VOICES(3), .ADDR_W(12), .DATA_W(8), .ROM_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .sample_strobe(sample_strobe), .voice_en(voice_en),
    .voice_addrs(voice_addrs), .rom_en(rom_en2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .voice_data(vd2), .data_valid(data_valid2), .busy(busy2), .overrun_cnt(ovr2),
    .state_dbg(st2)
  );

  // Un-tagged cycles return 0x5A so stray captures show up as wrong data.
  always @(posedge clk) begin
    rom_data1 <= rom_en1 ? (rom_addr1[7:0] ^ 8'hA5) : 8'h5A;
    rom_pipe2 <= rom_en2 ? (rom_addr2[7:0] ^ 8'hA5) : 8'h5A;
    rom_data2 <= rom_pipe2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic s);
    @(posedge clk);
    #1;
    sample_strobe = s;
    @(negedge clk);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " rom_en1"}, 32'(rom_en1), 0);
    chk({tag, " rom_addr1"}, 32'(rom_addr1), 0);
    chk({tag, " vd1"}, 32'(vd1), 0);
    chk({tag, " dv1"}, 32'(data_valid1), 0);
    chk({tag, " busy1"}, 32'(busy1), 0);
    chk({tag, " ovr1"}, 32'(ovr1), 0);
    chk({tag, " rom_en2"}, 32'(rom_en2), 0);
    chk({tag, " rom_addr2"}, 32'(rom_addr2), 0);
    chk({tag, " vd2"}, 32'(vd2), 0);
    chk({tag, " dv2"}, 32'(data_valid2), 0);
    chk({tag, " busy2"}, 32'(busy2), 0);
    chk({tag, " ovr2"}, 32'(ovr2), 0);
  endtask

  // One sweep with the strobe in cycle 0; inputs are scrambled in cycle 1 to prove the snapshot is used.
  task automatic run_sweep(input string tag, input logic [2:0] en, input logic [35:0] addrs,
                           input logic [23:0] exp_vd);
    logic [11:0] exp_q[$];
    int k;
    logic e_en, e_dv1, e_dv2, e_b1, e_b2;
    logic [11:0] e_addr;
    for (int i = 0; i < 3; i++) if (en[i]) exp_q.push_back(addrs[i*12 +: 12]);
    k = exp_q.size();
    voice_en = en;
    voice_addrs = addrs;
    for (int c = 0; c <= k + 5; c++) begin
      step(c == 0);
      if (c == 1) begin
        voice_en = 3'($urandom_range(0, 7));
        voice_addrs = {4'($urandom), $urandom};
      end
      e_en   = (k > 0) && (c >= 1) && (c <= k);
      e_addr = e_en ? exp_q[c-1] : 12'h000;
      e_dv1  = (k > 0) ? (c == k + 2) : (c == 1);
      e_dv2  = (k > 0) ? (c == k + 3) : (c == 1);
      e_b1   = (k > 0) && (c >= 1) && (c <= k + 1);
      e_b2   = (k > 0) && (c >= 1) && (c <= k + 2);
      chk($sformatf("%s c%0d rom_en1", tag, c), 32'(rom_en1), 32'(e_en));
      chk($sformatf("%s c%0d rom_addr1", tag, c), 32'(rom_addr1), 32'(e_addr));
      chk($sformatf("%s c%0d rom_en2", tag, c), 32'(rom_en2), 32'(e_en));
      chk($sformatf("%s c%0d rom_addr2", tag, c), 32'(rom_addr2), 32'(e_addr));
      chk($sformatf("%s c%0d dv1", tag, c), 32'(data_valid1), 32'(e_dv1));
      chk($sformatf("%s c%0d dv2", tag, c), 32'(data_valid2), 32'(e_dv2));
      chk($sformatf("%s c%0d busy1", tag, c), 32'(busy1), 32'(e_b1));
      chk($sformatf("%s c%0d busy2", tag, c), 32'(busy2), 32'(e_b2));
      if (e_dv1) chk($sformatf("%s c%0d vd1", tag, c), 32'(vd1), 32'(exp_vd));
      if (e_dv2) chk($sformatf("%s c%0d vd2", tag, c), 32'(vd2), 32'(exp_vd));
    end
    chk({tag, " vd1 held"}, 32'(vd1), 32'(exp_vd));
    chk({tag, " vd2 held"}, 32'(vd2), 32'(exp_vd));
  endtask

  localparam logic [35:0] STD_ADDRS = {12'h030, 12'h020, 12'h010};

  initial begin
    // Reset held while the clock and inputs toggle.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      sample_strobe = 1'($urandom_range(0, 1));
      voice_en = 3'($urandom_range(0, 7));
      voice_addrs = {4'($urandom), $urandom};
    end
    @(negedge clk);
    chk_idle_zero("in reset");
    @(posedge clk);
    #1;
    sample_strobe = 1'b0;
    rst_n = 1'b1;
    step(1'b0);
    step(1'b0);
    chk_idle_zero("after release");
    chk("state1 idle", 32'(st1), 0);

    run_sweep("full", 3'b111, STD_ADDRS, 24'h9585B5);
    run_sweep("partial", 3'b101, STD_ADDRS, 24'h9500B5);
    run_sweep("none", 3'b000, STD_ADDRS, 24'h000000);
    run_sweep("mixed", 3'b110, {12'h456, 12'h123, 12'h0FF}, 24'hF38600);
    run_sweep("single", 3'b001, {12'h456, 12'h123, 12'h0FF}, 24'h00005A);

    // Overrun: strobes in cycles 0, 2, 3, 5 with all voices enabled.
    voice_en = 3'b111;
    voice_addrs = STD_ADDRS;
    step(1'b1);
    step(1'b0);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    chk("ovr c4 ovr1", 32'(ovr1), 2);
    chk("ovr c4 ovr2", 32'(ovr2), 2);
    step(1'b1);
    chk("ovr c5 dv1", 32'(data_valid1), 1);
    chk("ovr c5 vd1", 32'(vd1), 32'h9585B5);
    chk("ovr c5 dv2", 32'(data_valid2), 0);
    step(1'b0);
    chk("ovr c6 rom_en1", 32'(rom_en1), 1);
    chk("ovr c6 rom_addr1", 32'(rom_addr1), 32'h010);
    chk("ovr c6 dv2", 32'(data_valid2), 1);
    chk("ovr c6 vd2", 32'(vd2), 32'h9585B5);
    chk("ovr c6 ovr1", 32'(ovr1), 2);
    chk("ovr c6 ovr2", 32'(ovr2), 3);
    step(1'b0);
    chk("ovr c7 rom_addr1", 32'(rom_addr1), 32'h020);
    step(1'b0);
    chk("ovr c8 rom_addr1", 32'(rom_addr1), 32'h030);
    chk("ovr c8 rom_en2", 32'(rom_en2), 0);
    step(1'b0);
    chk("ovr c9 rom_en1", 32'(rom_en1), 0);
    step(1'b0);
    chk("ovr c10 dv1", 32'(data_valid1), 1);
    chk("ovr c10 vd1", 32'(vd1), 32'h9585B5);
    step(1'b0);

    // Continuous strobes drop well over 255 requests on both instances.
    for (int i = 0; i < 400; i++) step(1'b1);
    for (int i = 0; i < 10; i++) step(1'b0);
    chk("sat ovr1", 32'(ovr1), 255);
    chk("sat ovr2", 32'(ovr2), 255);
    chk("sat busy1", 32'(busy1), 0);
    chk("sat vd2", 32'(vd2), 32'h9585B5);

    // Reset asserted in cycle 3 of a sweep.
    voice_en = 3'b111;
    voice_addrs = STD_ADDRS;
    step(1'b1);
    step(1'b0);
    step(1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_zero("mid reset");
    step(1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int c = 6; c <= 10; c++) begin
      step(1'b0);
      chk($sformatf("post reset c%0d dv1", c), 32'(data_valid1), 0);
      chk($sformatf("post reset c%0d dv2", c), 32'(data_valid2), 0);
      chk($sformatf("post reset c%0d vd2", c), 32'(vd2), 0);
    end
    run_sweep("after reset", 3'b111, STD_ADDRS, 24'h9585B5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wave_rom_scheduler.md
Name: wave_rom_scheduler

Overview:
- Time-multiplexes one synchronous-read waveform ROM (sine, triangle, square or saw) among NUM_VOICES note channels.
- On each sample strobe it snapshots the per-voice wave-counter addresses and enables.
- It issues one ROM read per enabled voice, in index order, and tags every read so returned data lands in the correct voice slot for any ROM latency.
- It publishes all voice samples together, with one valid pulse. It sits between the wave-counter block and the combiner, one instance per waveform ROM.

Parameters:
NUM_VOICES, 3, number of voice channels served
ADDR_W, 12, ROM address width
DATA_W, 8, ROM sample width
ROM_LAT, 1, cycles from rom_en/rom_addr sampled to rom_data valid (1..4)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
sample_strobe  in  1  one-cycle request to start a sweep
voice_en  in  NUM_VOICES  per-voice enable, bit i = voice i
voice_addrs  in  NUM_VOICES*ADDR_W  voice i address at [i*ADDR_W +: ADDR_W]
rom_en  out  1  ROM read enable
rom_addr  out  ADDR_W  ROM read address
rom_data  in  DATA_W  ROM read data
voice_data  out  NUM_VOICES*DATA_W  published samples, voice i at [i*DATA_W +: DATA_W]
data_valid  out  1  one-cycle pulse: voice_data updated
busy  out  1  sweep in progress
overrun_cnt  out  8  saturating count of dropped strobes

Behaviour:
- Reset (async assert, sync release): state IDLE. The following are all 0: rom_en, rom_addr, voice_data, data_valid, busy, overrun_cnt, tag pipeline and working slots.
- States and transitions:
  - IDLE: on sample_strobe, latch voice_en and voice_addrs into snapshot registers. Go to ISSUE if any snapshot enable is set, else go to DONE.
  - ISSUE: each cycle, present the next enabled voice (lowest index first) with rom_en=1 and rom_addr=snapshot address. Disabled voices are skipped and consume no cycle. After the last enabled voice, go to DRAIN.
  - DRAIN: wait until the tag pipeline is empty, then go to DONE.
  - DONE: one cycle. data_valid=1; voice_data is loaded from the working slots in the same edge as data_valid rises, so it is stable for the whole pulse. A sample_strobe in DONE is accepted exactly as in IDLE (new snapshot, next state ISSUE/DONE); otherwise go to IDLE.
- Tag pipeline: ROM_LAT-deep shift register of {valid, voice index}, loaded on each issue cycle.
  - When a valid tag exits, rom_data is written into working slot[index].
  - Data with no valid tag is ignored.
- Slot clearing: working slots are cleared to 0 at snapshot time. Disabled voices therefore publish 0.
- Latency, with strobe in cycle 0 and k enabled voices:
  - k>0: rom_en is high in cycles 1..k and data_valid is high in cycle k+ROM_LAT+1.
  - k=0: data_valid is high in cycle 1 and rom_en never asserts.
- rom_addr is forced to 0 whenever rom_en=0.
- busy=1 in ISSUE and DRAIN, 0 in IDLE and DONE.
- Overrun: a sample_strobe in ISSUE or DRAIN is dropped and overrun_cnt increments, saturating at 255. The running sweep is unaffected. overrun_cnt is cleared only by reset.
- Input changes during a sweep have no effect; only the snapshot is used.
- Reset mid-sweep: abort immediately. No data_valid is produced, in-flight tags are discarded, and voice_data returns to 0.
- voice_data holds its last published value between sweeps.

Test Plan:
- Reset: hold rst_n=0, toggle clk and inputs -> all outputs 0. Release -> IDLE, busy=0.
- Full sweep, ROM_LAT=1, ROM model data=addr[7:0]^0xA5, voice_en=3'b111, addrs 0x010/0x020/0x030, strobe in cycle 0:
  - rom_en high in cycles 1-3 with rom_addr 0x010, 0x020, 0x030.
  - data_valid only in cycle 5, with voice_data = v0 0xB5, v1 0x85, v2 0x95.
- Partial enables, voice_en=3'b101, same addrs and ROM model:
  - rom_en high in cycles 1-2 with addrs 0x010, 0x030.
  - data_valid in cycle 4, with v0=0xB5, v1=0x00, v2=0x95.
- No enables, voice_en=0: rom_en never high; data_valid in cycle 1; voice_data all 0.
- Overrun and back-to-back:
  - Strobes in cycles 0, 2, 3 (all enabled) -> overrun_cnt=2 and the first sweep's result is intact at cycle 5.
  - A strobe in cycle 5 (DONE) is accepted: rom_en high in cycles 6-8.
  - 300 dropped strobes -> overrun_cnt=255.
- ROM_LAT=2 and reset mid-sweep:
  - ROM_LAT=2, all enabled -> data_valid in cycle 6 with correct slot mapping.
  - Repeat with rst_n low in cycle 3 -> no data_valid, voice_data=0.
  - Next strobe completes normally.
